tcam_ram_row: RTL and testbench
===============================

TCAM_RAM_ROW -- requirements
Module: tcam_ram_row

Interface
REQ-001 Parameter KEY_W, 8, lookup key width; memory depth is 2^KEY_W words.
REQ-002 Parameter NUM_RULES, 120, number of ternary rules, which is also the match vector width.
REQ-003 Parameter ID_W, $clog2(NUM_RULES), rule index width.
REQ-004 write_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 upd_valid  in  1  update request.
REQ-007 upd_ready  out  1  update engine idle; request accepted when upd_valid && upd_ready.
REQ-008 upd_op  in  1  1 = install, 0 = delete.
REQ-009 upd_rule_id  in  ID_W  rule being updated.
REQ-010 upd_value  in  KEY_W  rule value.
REQ-011 upd_mask  in  KEY_W  care mask; 1 = compare bit, 0 = wildcard.
REQ-012 upd_done  out  1  one-cycle pulse on update completion.
REQ-013 lk_valid  in  1  lookup request, accepted every cycle, no backpressure.
REQ-014 lk_key  in  KEY_W  lookup key, used as the memory read address.
REQ-015 lk_out_valid  out  1  lookup result valid.
REQ-016 match  out  NUM_RULES  per-rule hit vector.
REQ-017 hit  out  1  OR of match.
REQ-018 hit_idx  out  ID_W  lowest-index set bit of match; 0 when hit = 0.

Function
REQ-019 Storage: 2^KEY_W words x NUM_RULES bits; one read port and one write port with per-bit write enable; a read and write to the same address in one cycle returns old data.
REQ-020 Register rule_vld[NUM_RULES]; stored column bits count only where rule_vld = 1.
REQ-021 FSM states: IDLE and SWEEP; upd_ready = 1 only in IDLE.
REQ-022 Install accept in IDLE: clear rule_vld[id], latch id/value/mask, clear addr counter, go to SWEEP.
REQ-023 SWEEP: each cycle write bit id at address addr with ((addr ^ value) & mask) == 0, then addr++; exactly 2^KEY_W cycles, covering all addresses, with both 1s and 0s written.
REQ-024 Last address (addr = 2^KEY_W-1) written: set rule_vld[id], return to IDLE, and assert upd_done in the following cycle.
REQ-025 Delete accept: clear rule_vld[id] in the accept cycle, no memory writes, stay in IDLE, and assert upd_done in the next cycle.
REQ-026 upd_rule_id >= NUM_RULES: accepted, no state change, and upd_done pulses in the next cycle.
REQ-027 Lookup at cycle t: memory read registered at t+1; match/hit/hit_idx and lk_out_valid registered at t+2; latency is fixed at 2, and lookups are fully pipelined.
REQ-028 match = read word & rule_vld, with rule_vld sampled in cycle t+1; a rule under sweep therefore never matches.
REQ-029 Lookups are not stalled or corrupted by a concurrent update.
REQ-030 Re-installing an already valid id overwrites its whole column; the rule is invisible during the sweep.

Reset
REQ-031 While rst_n = 0 at a clock edge: state = IDLE, addr = 0, rule_vld = 0, upd_done = 0, lk_out_valid = 0, match = 0, hit = 0, hit_idx = 0, and pipeline valids are cleared.
REQ-032 Memory contents are not reset; they are masked by rule_vld.
REQ-033 Reset mid-SWEEP aborts the update with no upd_done, and upd_ready = 1 in the first cycle after release.

Structure
REQ-034 Package tcam_pkg holds the FSM state enum and the shared defaults for KEY_W and NUM_RULES.
REQ-035 One sub-module, tcam_prio_enc, is parametrised on NUM_RULES and is purely combinational: vector in, hit and hit_idx out.

Verification (KEY_W = 8, NUM_RULES = 120)
REQ-036 Reset, then lookup 0x00 -> at t+2: lk_out_valid = 1, match = 0, hit = 0, hit_idx = 0.
REQ-037 Install id 5, value 0xA0, mask 0xF0 -> upd_ready low for 256 cycles, upd_done one cycle after the last write; lookup 0xA7 -> match[5] = 1, hit_idx = 5; lookup 0xB0 -> hit = 0.
REQ-038 Install id 3, mask 0x00 -> lookup 0xA7 gives match bits 3 and 5, hit_idx = 3; lookups issued during the id 3 sweep give match[3] = 0 and match[5] = 1.
REQ-039 Delete id 3 -> upd_done next cycle; lookup 0xA7 -> hit_idx = 5; a back-to-back lookup stream issued across the delete gives the switchover exactly per REQ-028.
REQ-040 Reset at sweep address 100 -> no upd_done, upd_ready = 1 after release, and every lookup 0x00-0xFF gives hit = 0.
REQ-041 Out-of-range update id 127 -> upd_done next cycle, upd_ready never drops, and match is unchanged.

Source files
------------

// File: rtl/tcam_pkg.sv
`default_nettype none
// ============================================================================
// tcam_pkg : shared defaults and update-engine state encoding for tcam_ram_row
// Revision : 1.0
// ============================================================================
package tcam_pkg;

    localparam int c_default_key_w     = 8;
    localparam int c_default_num_rules = 120;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } upd_state_e;

endpackage
`default_nettype wire

// File: rtl/tcam_prio_enc.sv
`default_nettype none
// ============================================================================
// tcam_prio_enc : combinational lowest-index priority encoder over a hit vector
// Revision      : 1.0
// ============================================================================
module tcam_prio_enc #(
    parameter int NUM_RULES = 120,
    localparam int ID_W     = $clog2(NUM_RULES)
) (
    input  logic [NUM_RULES-1:0] i_vec,
    output logic                 o_hit,
    output logic [ID_W-1:0]      o_hit_idx
);

    always_comb begin
        o_hit     = |i_vec;
        o_hit_idx = '0;
        // Scan downward so the lowest set index is the one left standing.
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_hit_idx = ID_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tcam_ram_row.sv
`default_nettype none
// ============================================================================
// tcam_ram_row : RAM-based TCAM, one memory word per key, one column per rule
// Revision     : 1.0
// ============================================================================
module tcam_ram_row
    import tcam_pkg::*;
#(
    parameter int KEY_W     = c_default_key_w,
    parameter int NUM_RULES = c_default_num_rules,
    parameter int ID_W      = $clog2(NUM_RULES)
) (
    input  logic                 write_clk,
    input  logic                 rst_n,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic                 upd_op,
    input  logic [ID_W-1:0]      upd_rule_id,
    input  logic [KEY_W-1:0]     upd_value,
    input  logic [KEY_W-1:0]     upd_mask,
    output logic                 upd_done,
    input  logic                 lk_valid,
    input  logic [KEY_W-1:0]     lk_key,
    output logic                 lk_out_valid,
    output logic [NUM_RULES-1:0] match,
    output logic                 hit,
    output logic [ID_W-1:0]      hit_idx
);

    localparam int DEPTH = 2 ** KEY_W;

    logic [NUM_RULES-1:0] mem [DEPTH];
    logic [NUM_RULES-1:0] rd_data_q;

    upd_state_e           state_q, state_d;
    logic [KEY_W-1:0]     addr_q, addr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [KEY_W-1:0]     value_q, value_d;
    logic [KEY_W-1:0]     mask_q, mask_d;
    logic [NUM_RULES-1:0] rule_vld_q, rule_vld_d;
    logic                 upd_done_q, upd_done_d;

    logic                 s1_valid_q, s1_valid_d;
    logic                 out_valid_q, out_valid_d;
    logic [NUM_RULES-1:0] match_q, match_d;
    logic                 hit_q, hit_d;
    logic [ID_W-1:0]      hit_idx_q, hit_idx_d;

    logic                 id_in_range;
    logic                 wr_en;
    logic                 wr_bit;
    logic [NUM_RULES-1:0] match_new;
    logic                 enc_hit;
    logic [ID_W-1:0]      enc_idx;

    assign id_in_range = ({1'b0, upd_rule_id} < (ID_W + 1)'(NUM_RULES));
    assign wr_bit      = (((addr_q ^ value_q) & mask_q) == '0);
    // Writes are held off during reset so an aborted sweep stops cleanly.
    assign wr_en       = (state_q == ST_SWEEP) && rst_n;
    assign match_new   = rd_data_q & rule_vld_q;

    tcam_prio_enc #(
        .NUM_RULES (NUM_RULES)
    ) u_prio_enc (
        .i_vec     (match_new),
        .o_hit     (enc_hit),
        .o_hit_idx (enc_idx)
    );

    // Storage is never reset; stale columns are hidden by rule_vld.
    always_ff @(posedge write_clk) begin
        if (wr_en) begin
            mem[addr_q][id_q] <= wr_bit;
        end
        rd_data_q <= mem[lk_key];
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        id_d       = id_q;
        value_d    = value_q;
        mask_d     = mask_q;
        rule_vld_d = rule_vld_q;
        upd_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (upd_valid) begin
                    if (!id_in_range) begin
                        upd_done_d = 1'b1;
                    end else if (upd_op) begin
                        rule_vld_d[upd_rule_id] = 1'b0;
                        id_d    = upd_rule_id;
                        value_d = upd_value;
                        mask_d  = upd_mask;
                        addr_d  = '0;
                        state_d = ST_SWEEP;
                    end else begin
                        rule_vld_d[upd_rule_id] = 1'b0;
                        upd_done_d = 1'b1;
                    end
                end
            end
            ST_SWEEP: begin
                addr_d = addr_q + KEY_W'(1);
                if (addr_q == '1) begin
                    rule_vld_d[id_q] = 1'b1;
                    upd_done_d       = 1'b1;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s1_valid_d  = lk_valid;
        out_valid_d = s1_valid_q;
        match_d     = match_q;
        hit_d       = hit_q;
        hit_idx_d   = hit_idx_q;
        if (s1_valid_q) begin
            match_d   = match_new;
            hit_d     = enc_hit;
            hit_idx_d = enc_idx;
        end
    end

    always_ff @(posedge write_clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            id_q        <= '0;
            value_q     <= '0;
            mask_q      <= '0;
            rule_vld_q  <= '0;
            upd_done_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            match_q     <= '0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            id_q        <= id_d;
            value_q     <= value_d;
            mask_q      <= mask_d;
            rule_vld_q  <= rule_vld_d;
            upd_done_q  <= upd_done_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            match_q     <= match_d;
            hit_q       <= hit_d;
            hit_idx_q   <= hit_idx_d;
        end
    end

    assign upd_ready    = (state_q == ST_IDLE);
    assign upd_done     = upd_done_q;
    assign lk_out_valid = out_valid_q;
    assign match        = match_q;
    assign hit          = hit_q;
    assign hit_idx      = hit_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_tcam_ram_row.sv
`default_nettype none
// ============================================================================
// tb_tcam_ram_row : randomized bench for tcam_ram_row against a rule-table model
// Revision        : 1.0
// ============================================================================
module tb_tcam_ram_row;

    localparam int KEY_W = 8;
    localparam int NR    = 120;
    localparam int ID_W  = 7;

    logic            write_clk = 1'b0;
    logic            rst_n;
    logic            upd_valid;
    logic            upd_ready;
    logic            upd_op;
    logic [ID_W-1:0] upd_rule_id;
    logic [KEY_W-1:0] upd_value;
    logic [KEY_W-1:0] upd_mask;
    logic            upd_done;
    logic            lk_valid;
    logic [KEY_W-1:0] lk_key;
    logic            lk_out_valid;
    logic [NR-1:0]   match;
    logic            hit;
    logic [ID_W-1:0] hit_idx;

    tcam_ram_row #(.KEY_W(KEY_W), .NUM_RULES(NR)) dut (
        .write_clk    (write_clk),
        .rst_n        (rst_n),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_op       (upd_op),
        .upd_rule_id  (upd_rule_id),
        .upd_value    (upd_value),
        .upd_mask     (upd_mask),
        .upd_done     (upd_done),
        .lk_valid     (lk_valid),
        .lk_key       (lk_key),
        .lk_out_valid (lk_out_valid),
        .match        (match),
        .hit          (hit),
        .hit_idx      (hit_idx)
    );

    always #5 write_clk = ~write_clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [ID_W-1:0] lowest(input bit [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (v[i]) return 7'(i);
        end
        return '0;
    endfunction

    // Reference model: rule table timeline plus a per-address column image.
    bit [NR-1:0] m_mem   [256];
    bit [NR-1:0] m_known [256];
    bit [NR-1:0] m_vld;
    bit          m_busy, m_done;
    int          m_acc, ecount;
    bit [ID_W-1:0]  m_id;
    bit [KEY_W-1:0] m_val, m_msk;
    bit          e_s1_v, e_s1_skip, e_out_v, e_skip, e_hit;
    bit [NR-1:0] e_s1_match, e_match;
    bit [ID_W-1:0] e_idx;

    always @(posedge write_clk) begin
        bit wr;
        int wa;
        bit [ID_W-1:0] wid;
        bit wb;
        ecount++;
        wr = 1'b0;
        if (!rst_n) begin
            m_busy = 0; m_vld = '0; m_done = 0;
            e_s1_v = 0; e_s1_skip = 0; e_out_v = 0; e_skip = 0;
            e_match = '0; e_hit = 0; e_idx = '0;
        end else begin
            e_out_v = e_s1_v;
            if (e_s1_v) begin
                e_match = e_s1_match;
                e_skip  = e_s1_skip;
                e_hit   = |e_match;
                e_idx   = lowest(e_match);
            end
            m_done = 1'b0;
            if (m_busy) begin
                wa  = ecount - m_acc - 1;
                wr  = 1'b1;
                wid = m_id;
                wb  = (((8'(wa) ^ m_val) & m_msk) == 8'h00);
                if (wa == 255) begin
                    m_busy = 0; m_vld[m_id] = 1'b1; m_done = 1'b1;
                end
            end else if (upd_valid) begin
                if (upd_rule_id >= NR) begin
                    m_done = 1'b1;
                end else if (upd_op) begin
                    m_vld[upd_rule_id] = 1'b0;
                    m_busy = 1'b1; m_acc = ecount;
                    m_id = upd_rule_id; m_val = upd_value; m_msk = upd_mask;
                end else begin
                    m_vld[upd_rule_id] = 1'b0;
                    m_done = 1'b1;
                end
            end
            e_s1_v     = lk_valid;
            e_s1_match = m_vld & m_mem[lk_key];
            e_s1_skip  = |(m_vld & ~m_known[lk_key]);
            if (wr) begin
                m_mem[wa][wid]   = wb;
                m_known[wa][wid] = 1'b1;
            end
        end
    end

    always @(negedge write_clk) begin
        if (chk_en) begin
            check_eq("upd_ready", upd_ready, !m_busy);
            check_eq("upd_done", upd_done, m_done);
            check_eq("lk_out_valid", lk_out_valid, e_out_v);
            if (!e_skip) begin
                check_eq("match", match, e_match);
                check_eq("hit", hit, e_hit);
                check_eq("hit_idx", hit_idx, e_idx);
            end
        end
    end

    // Lookup generator: 0 = random, 1 = fixed key every cycle, 2 = full key sweep.
    int          lk_mode = 0;
    logic [7:0]  lk_hot  = 8'h00;
    logic [7:0]  sweep_key = 8'h00;

    initial begin
        lk_valid = 1'b0;
        lk_key   = '0;
        forever begin
            @(negedge write_clk);
            if (lk_mode == 1) begin
                lk_valid = 1'b1;
                lk_key   = lk_hot;
            end else if (lk_mode == 2) begin
                lk_valid  = 1'b1;
                lk_key    = sweep_key;
                sweep_key = sweep_key + 8'd1;
            end else begin
                lk_valid = ($urandom_range(0, 7) != 0);
                case ($urandom_range(0, 4))
                    0:       lk_key = 8'hA7;
                    1:       lk_key = 8'hB0;
                    2:       lk_key = 8'h00;
                    3:       lk_key = 8'hFF;
                    default: lk_key = 8'($urandom);
                endcase
            end
        end
    end

    task automatic do_update(input bit op, input int id, input logic [7:0] v, input logic [7:0] m);
        @(negedge write_clk);
        upd_valid   = 1'b1;
        upd_op      = op;
        upd_rule_id = 7'(id);
        upd_value   = v;
        upd_mask    = m;
        @(negedge write_clk);
        upd_valid   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; upd_valid = 1'b0; upd_op = 1'b0;
        upd_rule_id = '0; upd_value = '0; upd_mask = '0;
        repeat (3) @(posedge write_clk);
        chk_en = 1'b1;
        @(negedge write_clk);
        rst_n = 1'b1;
        lk_mode = 1; lk_hot = 8'h00;
        repeat (4) @(negedge write_clk);
        lk_mode = 0;

        do_update(1'b1, 5, 8'hA0, 8'hF0);
        repeat (258) @(negedge write_clk);

        lk_mode = 1; lk_hot = 8'hA7;
        do_update(1'b1, 3, 8'($urandom), 8'h00);
        repeat (258) @(negedge write_clk);

        do_update(1'b0, 3, 8'h00, 8'h00);
        repeat (5) @(negedge write_clk);
        lk_mode = 0;

        // A request raised mid-sweep must be ignored.
        do_update(1'b1, 119, 8'($urandom), 8'($urandom));
        repeat (50) @(negedge write_clk);
        do_update(1'b0, 5, 8'h00, 8'h00);
        repeat (210) @(negedge write_clk);

        do_update(1'b1, 0, 8'hFF, 8'h81);
        repeat (258) @(negedge write_clk);

        lk_mode = 1; lk_hot = 8'hA7;
        do_update(1'b1, 5, 8'h27, 8'h7F);
        repeat (258) @(negedge write_clk);
        lk_mode = 0;

        do_update(1'b1, 127, 8'h00, 8'h00);
        repeat (3) @(negedge write_clk);
        do_update(1'b0, 127, 8'h00, 8'h00);
        repeat (3) @(negedge write_clk);

        // Reset lands while the sweep address register holds 100.
        do_update(1'b1, 10, 8'h00, 8'h00);
        repeat (100) @(negedge write_clk);
        rst_n = 1'b0;
        repeat (2) @(negedge write_clk);
        rst_n = 1'b1;
        sweep_key = 8'h00;
        lk_mode = 2;
        repeat (260) @(negedge write_clk);
        lk_mode = 0;

        for (int k = 0; k < 6; k++) begin
            bit op;
            op = ($urandom_range(0, 3) != 0);
            do_update(op, $urandom_range(0, 127), 8'($urandom), 8'($urandom));
            repeat (op ? 258 : 4) @(negedge write_clk);
        end

        repeat (5) @(negedge write_clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
